mux_tree_pipe: RTL and testbench

//  Parametrised, pipelined N:1 data multiplexer built as a binary tree of 2:1 selection levels.

---
 rtl/mux_tree_pipe.sv | 146 ++++++++++++++
 tb/tb_mux_tree_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_pipe.sv
// ============================================================================
// mux_tree_pipe : pipelined N_IN:1 binary mux tree, one register stage per
//                 level, valid/ready with full-pipeline backpressure.
//                 Optional MUX_TREE_SEL_CHECK_EN adds the sel_err output.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mux_tree_pipe #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_IN*DATA_W-1:0]     in_data,
  input  logic [$clog2(N_IN)-1:0]    in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
`ifdef MUX_TREE_SEL_CHECK_EN
  output logic                       sel_err,
`endif
  input  logic                       out_ready
);

  localparam int LVL    = $clog2(N_IN);
  localparam int N_PAD  = 1 << LVL;
  localparam int TREE_W = (2 * N_PAD - 1) * DATA_W;
  localparam int SEL_W  = LVL + (LVL * (LVL - 1)) / 2;

  // All levels share flat buses: region 0 is the padded input, region k+1
  // is the register stage after tree level k.
  function automatic int word_off(input int r);
    return (1 << (LVL + 1)) - (1 << (LVL + 1 - r));
  endfunction

  function automatic int sel_off(input int r);
    return r * LVL - (r * (r - 1)) / 2;
  endfunction

  logic [TREE_W-1:0] tree;
  logic [SEL_W-1:0]  sel_bus;
  logic [LVL:0]      vld_bus;
  logic              stall;

  assign stall    = vld_bus[LVL] & ~out_ready;
  assign in_ready = ~stall;

  assign tree[N_IN*DATA_W-1:0] = in_data;
  assign sel_bus[LVL-1:0]      = in_sel;
  assign vld_bus[0]            = in_valid;

  if (N_PAD > N_IN) begin : g_pad
    assign tree[N_PAD*DATA_W-1:N_IN*DATA_W] = '0;
  end

  for (genvar k = 0; k < LVL; k++) begin : g_stage
    localparam int NW   = 1 << (LVL - 1 - k);
    localparam int SRC  = word_off(k) * DATA_W;
    localparam int DST  = word_off(k + 1) * DATA_W;
    localparam int SSRC = sel_off(k);
    localparam int SDST = sel_off(k + 1);

    logic [NW*DATA_W-1:0] data_d, data_q;
    logic                 valid_d, valid_q;

    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (!stall) begin
        valid_d = vld_bus[k];
        for (int j = 0; j < NW; j++) begin
          data_d[j*DATA_W +: DATA_W] = sel_bus[SSRC]
              ? tree[SRC + (2*j+1)*DATA_W +: DATA_W]
              : tree[SRC + (2*j)*DATA_W   +: DATA_W];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign tree[DST +: NW*DATA_W] = data_q;
    assign vld_bus[k+1]           = valid_q;

    // Remaining select bits ride along; the last stage needs none.
    if (k < LVL - 1) begin : g_sel
      localparam int SW = LVL - 1 - k;
      logic [SW-1:0] sel_d, sel_q;

      always_comb begin
        sel_d = sel_q;
        if (!stall) sel_d = sel_bus[SSRC+1 +: SW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_q <= '0;
        else        sel_q <= sel_d;
      end

      assign sel_bus[SDST +: SW] = sel_q;
    end
  end

  assign out_data  = tree[TREE_W-1 -: DATA_W];
  assign out_valid = vld_bus[LVL];

`ifdef MUX_TREE_SEL_CHECK_EN
  if (N_PAD != N_IN) begin : g_flag
    logic [LVL:0] flg_bus;
    assign flg_bus[0] = (in_sel >= LVL'(N_IN));

    for (genvar k = 0; k < LVL; k++) begin : g_flg_stage
      logic flg_d, flg_q;

      always_comb begin
        flg_d = flg_q;
        if (!stall) flg_d = flg_bus[k];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flg_q <= 1'b0;
        else        flg_q <= flg_d;
      end

      assign flg_bus[k+1] = flg_q;
    end

    // Flag registers load regardless of valid, so gate with out_valid.
    assign sel_err = flg_bus[LVL] & vld_bus[LVL];
  end else begin : g_no_flag
    assign sel_err = 1'b0;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: directed literal tests plus a
// randomized run checked against a delay-line model and an order queue.
`default_nettype none

module tb_mux_tree_pipe;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data = '0;
  logic [2:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sel_err;

  logic [39:0] in5_data = '0;
  logic [2:0]  in5_sel = '0;
  logic        in5_valid = 1'b0;
  logic        in5_ready;
  logic [7:0]  out5_data;
  logic        out5_valid;
  logic        sel5_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mux_tree_pipe #(.DATA_W(8), .N_IN(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid),
`ifdef MUX_TREE_SEL_CHECK_EN
    .sel_err(sel_err),
`endif
    .out_ready(out_ready)
  );

  mux_tree_pipe #(.DATA_W(8), .N_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in5_data), .in_sel(in5_sel),
    .in_valid(in5_valid), .in_ready(in5_ready), .out_data(out5_data),
    .out_valid(out5_valid),
`ifdef MUX_TREE_SEL_CHECK_EN
    .sel_err(sel5_err),
`endif
    .out_ready(1'b1)
  );

`ifndef MUX_TREE_SEL_CHECK_EN
  assign sel_err  = 1'b0;
  assign sel5_err = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [7:0] pick(input logic [63:0] d, input int s, input int n);
    return (s < n) ? d[s*8 +: 8] : 8'h00;
  endfunction

  // Reference: fixed LAT-slot delay line that moves only when the output is
  // not stalled, plus an in-order queue of accepted words.
  bit        m_v [LAT];
  bit [7:0]  m_d [LAT];
  bit [7:0]  exp_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        m_v[k] = 1'b0;
        m_d[k] = 8'h00;
      end
      exp_q.delete();
    end else if (!(m_v[LAT-1] && !out_ready)) begin
      for (int k = LAT-1; k > 0; k--) begin
        m_v[k] = m_v[k-1];
        m_d[k] = m_d[k-1];
      end
      m_v[0] = in_valid;
      m_d[0] = pick(in_data, int'(in_sel), 8);
    end
  end

  always @(negedge clk) begin
    #1;
    chk("model_out_valid", {63'd0, out_valid}, {63'd0, m_v[LAT-1]});
    chk("model_in_ready", {63'd0, in_ready}, {63'd0, !(m_v[LAT-1] && !out_ready)});
    chk("sel_err_pow2", {63'd0, sel_err}, 64'd0);
    if (m_v[LAT-1]) chk("model_out_data", {56'd0, out_data}, {56'd0, m_d[LAT-1]});
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("queue_underflow", 64'd1, 64'd0);
      else chk("queue_order", {56'd0, out_data}, {56'd0, exp_q.pop_front()});
    end
    if (rst_n && in_valid && in_ready) exp_q.push_back(pick(in_data, int'(in_sel), 8));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_data", {56'd0, out_data}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // T1: single item, latency 3, one cycle wide
    in_data = 64'h1716151413121110;
    for (int i = 0; i < 6; i++) begin
      tick();
      in_valid = (i == 0);
      in_sel   = 3'd5;
      #1;
      chk("t1_valid", {63'd0, out_valid}, {63'd0, i == 3});
      if (i == 3) chk("t1_data", {56'd0, out_data}, 64'h15);
    end

    // T2: eight back-to-back selections
    for (int i = 0; i < 11; i++) begin
      tick();
      in_valid = (i < 8);
      in_sel   = 3'(i);
      #1;
      chk("t2_in_ready", {63'd0, in_ready}, 64'd1);
      if (i >= 3) begin
        chk("t2_valid", {63'd0, out_valid}, 64'd1);
        chk("t2_data", {56'd0, out_data}, 64'h10 + 64'(i - 3));
      end
    end

    // T3: backpressure for 4 cycles on the first result
    for (int i = 0; i < 11; i++) begin
      tick();
      in_valid  = (i < 3);
      in_sel    = 3'(i + 1);
      out_ready = !(i >= 3 && i < 7);
      #1;
      if (i >= 3 && i < 7) begin
        chk("t3_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("t3_hold_data", {56'd0, out_data}, 64'h11);
        chk("t3_hold_valid", {63'd0, out_valid}, 64'd1);
      end else if (i >= 7 && i < 10) begin
        chk("t3_drain_data", {56'd0, out_data}, 64'h11 + 64'(i - 7));
      end else if (i == 10) begin
        chk("t3_drain_done", {63'd0, out_valid}, 64'd0);
      end
    end
    out_ready = 1'b1;

    // T4: N_IN=5, in-range and pad selections
    in5_data = 40'h2423222120;
    for (int i = 0; i < 7; i++) begin
      tick();
      in5_valid = (i < 3);
      in5_sel   = (i == 0) ? 3'd4 : (i == 1) ? 3'd6 : 3'd1;
      #1;
      chk("t4_valid", {63'd0, out5_valid}, {63'd0, i >= 3 && i < 6});
      if (i == 3) chk("t4_word4", {56'd0, out5_data}, 64'h24);
      if (i == 4) chk("t4_pad_zero", {56'd0, out5_data}, 64'h00);
      if (i == 5) chk("t4_word1", {56'd0, out5_data}, 64'h21);
`ifdef MUX_TREE_SEL_CHECK_EN
      chk("t4_sel_err", {63'd0, sel5_err}, {63'd0, i == 4});
`endif
    end

    // T5: async reset with two items in flight
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid = (i < 2);
      in_sel   = 3'(i + 2);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_async_data", {56'd0, out_data}, 64'd0);
    chk("t5_in_ready_rst", {63'd0, in_ready}, 64'd1);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      rst_n    = 1'b1;
      in_valid = (i == 0);
      in_sel   = 3'd7;
      #1;
      chk("t5_valid", {63'd0, out_valid}, {63'd0, i == 3});
      if (i == 3) chk("t5_data", {56'd0, out_data}, 64'h17);
    end

    // T6: random traffic checked by the model and queue
    for (int c = 0; c < 10000; c++) begin
      tick();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    #2;
    chk("t6_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
